// File: rtl/event_stretcher.sv
// Stretches short event requests into long, human-visible pulses separated by a
// guaranteed low gap, queueing up to MAX_PENDING further events while a pulse runs.
module event_stretcher #(
   parameter int ON_LIMIT    = 2500000,
   parameter int OFF_LIMIT   = 1250000,
   parameter int MAX_PENDING = 3
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Event,
   output logic o_Stretched,
   output logic o_Busy,
   output logic o_Overflow
);

   localparam int CNT_MAX = (ON_LIMIT > OFF_LIMIT) ? ON_LIMIT : OFF_LIMIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PEND_W  = $clog2(MAX_PENDING + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;

   localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_LIMIT - 1);
   localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_LIMIT - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [PEND_W-1:0] r_pend;
   logic              r_prev_event;

   logic              w_event;
   logic              w_pend_full;
   logic [PEND_W:0]   w_eff_pend;
   logic [PEND_W:0]   w_eff_minus1;

   assign w_event      = i_Event & ~r_prev_event;
   assign w_pend_full  = (r_pend == PEND_MAX);
   // One extra bit: a stored full count plus a last-cycle event can exceed MAX_PENDING.
   assign w_eff_pend   = {1'b0, r_pend} + {{PEND_W{1'b0}}, w_event};
   assign w_eff_minus1 = w_eff_pend - {{PEND_W{1'b0}}, 1'b1};

   // State machine, counters and registered outputs.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_pend       <= '0;
         r_prev_event <= 1'b0;
         o_Stretched  <= 1'b0;
         o_Busy       <= 1'b0;
         o_Overflow   <= 1'b0;
      end else begin
         r_prev_event <= i_Event;
         o_Overflow   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_event) begin
                  r_state     <= ST_ON;
                  r_cnt       <= '0;
                  r_pend      <= '0;
                  o_Stretched <= 1'b1;
                  o_Busy      <= 1'b1;
               end else begin
                  o_Stretched <= 1'b0;
                  o_Busy      <= 1'b0;
               end
            end
            ST_ON: begin
               if (w_event) begin
                  if (w_pend_full) begin
                     o_Overflow <= 1'b1;
                  end else begin
                     r_pend <= r_pend + PEND_W'(1);
                  end
               end
               if (r_cnt == ON_LAST) begin
                  r_state     <= ST_OFF;
                  r_cnt       <= '0;
                  o_Stretched <= 1'b0;
               end else begin
                  r_cnt       <= r_cnt + CNT_W'(1);
                  o_Stretched <= 1'b1;
               end
               o_Busy <= 1'b1;
            end
            ST_OFF: begin
               if (r_cnt == OFF_LAST) begin
                  // An event in this final cycle joins the queue instead of being dropped.
                  r_cnt <= '0;
                  if (w_eff_pend != '0) begin
                     r_state     <= ST_ON;
                     r_pend      <= w_eff_minus1[PEND_W-1:0];
                     o_Stretched <= 1'b1;
                     o_Busy      <= 1'b1;
                  end else begin
                     r_state     <= ST_IDLE;
                     r_pend      <= '0;
                     o_Stretched <= 1'b0;
                     o_Busy      <= 1'b0;
                  end
               end else begin
                  if (w_event) begin
                     if (w_pend_full) begin
                        o_Overflow <= 1'b1;
                     end else begin
                        r_pend <= r_pend + PEND_W'(1);
                     end
                  end
                  r_cnt       <= r_cnt + CNT_W'(1);
                  o_Stretched <= 1'b0;
                  o_Busy      <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cnt       <= '0;
               r_pend      <= '0;
               o_Stretched <= 1'b0;
               o_Busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
